// File: rtl/isa_pkg.sv
// Shared ISA definitions for the fetch front end and the control-signal decoder.
// No logic of its own: opcode field position, opcode constants and a legality helper.
// Ports: none (package).
package isa_pkg;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 27;
  localparam int OPC_W   = OPC_MSB - OPC_LSB + 1;

  localparam logic [OPC_W-1:0] OP_RTYPE = 5'b00000;
  localparam logic [OPC_W-1:0] OP_ADDI  = 5'b00101;
  localparam logic [OPC_W-1:0] OP_SW    = 5'b00111;
  localparam logic [OPC_W-1:0] OP_LW    = 5'b01000;

  function automatic logic [OPC_W-1:0] opcode_of(input logic [31:0] word);
    return word[OPC_MSB:OPC_LSB];
  endfunction

  function automatic logic is_legal_opcode(input logic [OPC_W-1:0] op);
    logic legal;
    case (op)
      OP_RTYPE, OP_ADDI, OP_SW, OP_LW: legal = 1'b1;
      default:                         legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Purpose: 2-entry FIFO holding fetched {pc, word} pairs between fetch and decode.
// Latency: a push is visible at head the cycle after the write edge; head is combinational.
// Backpressure: push while full is accepted only together with a pop; flush wins over both.
// Ports: clock/reset, push+push_dat (write), pop (read head), flush (empty the queue),
//        full, count (occupancy 0..2), head (oldest entry).
module fetch_queue #(
  parameter int W = 44
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  input  logic         flush,
  output logic         full,
  output logic [1:0]   count,
  output logic [W-1:0] head
);

  logic [W-1:0] mem_q [2];
  logic         rd_ptr_q, rd_ptr_d;
  logic         wr_ptr_q, wr_ptr_d;
  logic [1:0]   count_q, count_d;
  logic         do_push, do_pop;

  assign full  = (count_q == 2'd2);
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  // When full, the write slot is the head slot; a same-cycle pop frees it,
  // and the head has already been consumed combinationally before the edge.
  assign do_pop  = pop & (count_q != 2'd0);
  assign do_push = push & (!full | do_pop);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (do_pop)  rd_ptr_d = ~rd_ptr_q;
      if (do_push) wr_ptr_d = ~wr_ptr_q;
      count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      for (int i = 0; i < 2; i++) mem_q[i] <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      if (do_push && !flush) mem_q[wr_ptr_q] <= push_dat;
    end
  end

endmodule

// File: rtl/imem_fetch_unit.sv
// Purpose: instruction fetch front end driving a synchronous imem and feeding decode.
// Latency: issue in cycle N, q_imem captured at end of N+1, insn_valid in N+2; 1 insn/cycle.
// Backpressure: insn_ready=0 fills the 2-entry queue, then issue stops and address_imem holds.
// Ports: clock/reset; address_imem/q_imem (memory side); redirect_valid/redirect_pc (PC load);
//        insn_valid/insn/insn_pc/insn_illegal/insn_ready (decode handshake).
module imem_fetch_unit
  import isa_pkg::*;
#(
  parameter int                ADDR_W   = 12,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clock,
  input  logic              reset,
  output logic [ADDR_W-1:0] address_imem,
  input  logic [31:0]       q_imem,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              insn_valid,
  output logic [31:0]       insn,
  output logic [ADDR_W-1:0] insn_pc,
  output logic              insn_illegal,
  input  logic              insn_ready
);

  localparam int QW = ADDR_W + 32;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] req_pc_q, req_pc_d;  // address of the word currently in flight
  logic              inflight_q, inflight_d;
  logic              kill_q, kill_d;

  logic              pop, issue, capture;
  logic              q_push, q_pop, q_full;
  logic [1:0]        q_count;
  logic [QW-1:0]     q_head;
  logic [2:0]        occ;

  assign pop = insn_valid & insn_ready;

  // Slots already committed (queued + in flight) after this cycle's pop.
  // pop implies count>=1, so this never underflows.
  assign occ   = {1'b0, q_count} + {2'b0, inflight_q} - {2'b0, pop};
  assign issue = !redirect_valid && (occ < 3'd2);

  // A redirect flushes the queue, so a response landing in the same cycle is dropped too.
  assign capture = inflight_q & !kill_q & !redirect_valid;
  assign q_push  = capture & (!q_full | q_pop);
  assign q_pop   = pop & !redirect_valid;

  always_comb begin
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    inflight_d = issue;
    kill_d     = redirect_valid & inflight_q & !kill_q;
    if (redirect_valid) begin
      pc_d = redirect_pc;
    end else if (issue) begin
      pc_d     = pc_q + ADDR_W'(1);
      req_pc_d = pc_q;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
      kill_q     <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
      kill_q     <= kill_d;
    end
  end

  fetch_queue #(.W(QW)) u_queue (
    .clock    (clock),
    .reset    (reset),
    .push     (q_push),
    .push_dat ({req_pc_q, q_imem}),
    .pop      (q_pop),
    .flush    (redirect_valid),
    .full     (q_full),
    .count    (q_count),
    .head     (q_head)
  );

  assign address_imem = pc_q;
  assign insn_valid   = (q_count != 2'd0);
  // Gate the head so idle outputs read as zero rather than stale queue contents.
  assign insn         = insn_valid ? q_head[31:0] : '0;
  assign insn_pc      = insn_valid ? q_head[QW-1:32] : '0;
  assign insn_illegal = insn_valid & !is_legal_opcode(opcode_of(q_head[31:0]));

endmodule

// File: tb/tb_imem_fetch_unit.sv
module tb_imem_fetch_unit;

  localparam int AW = 12;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] address_imem;
  logic [31:0]   q_imem;
  logic          redirect_valid = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic          insn_valid;
  logic [31:0]   insn;
  logic [AW-1:0] insn_pc;
  logic          insn_illegal;
  logic          insn_ready = 1'b1;

  always #5 clock = ~clock;

  imem_fetch_unit #(.ADDR_W(AW), .RESET_PC(12'h000)) dut (
    .clock          (clock),
    .reset          (reset),
    .address_imem   (address_imem),
    .q_imem         (q_imem),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .insn_valid     (insn_valid),
    .insn           (insn),
    .insn_pc        (insn_pc),
    .insn_illegal   (insn_illegal),
    .insn_ready     (insn_ready)
  );

  // Memory image: word carries its own address; a few addresses get special opcodes.
  function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
    logic [4:0] op;
    case (a)
      12'h200: op = 5'b00101;
      12'h201: op = 5'b11111;
      12'h202: op = 5'b00111;
      12'h203: op = 5'b01000;
      12'h204: op = 5'b10000;
      default: op = 5'b00000;
    endcase
    return {op, 15'h0, a};
  endfunction

  function automatic logic exp_illegal(input logic [31:0] w);
    logic [4:0] op;
    op = w[31:27];
    return !(op == 5'd0 || op == 5'd5 || op == 5'd7 || op == 5'd8);
  endfunction

  always @(posedge clock) q_imem <= mem_word(address_imem);

  int n_checks = 0;
  int n_fail   = 0;
  logic [AW-1:0] exp_q[$];
  logic mon_en = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic load_exp(input logic [AW-1:0] start);
    logic [AW-1:0] p;
    exp_q.delete();
    for (int i = 0; i < 64; i++) begin
      p = start + AW'(i);
      exp_q.push_back(p);
    end
  endtask

  // Scoreboard: every accepted instruction must be the next expected PC, with its word.
  always @(negedge clock) begin
    logic [AW-1:0] e;
    if (mon_en && !reset && insn_valid && insn_ready && !redirect_valid) begin
      if (exp_q.size() == 0) begin
        check_eq("sb_underflow", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check_eq("sb_pc", 32'(insn_pc), 32'(e));
        check_eq("sb_word", insn, mem_word(e));
        check_eq("sb_illegal", 32'(insn_illegal), 32'(exp_illegal(mem_word(e))));
      end
    end
  end

  // Reset just deasserted at a negedge: checks the N / N+1 / N+2 fetch latency.
  task automatic check_restart(input string tag);
    #1;
    check_eq({tag, "_addr_n"}, 32'(address_imem), 32'h000);
    check_eq({tag, "_valid_n"}, 32'(insn_valid), 32'd0);
    @(negedge clock);
    check_eq({tag, "_valid_n1"}, 32'(insn_valid), 32'd0);
    check_eq({tag, "_addr_n1"}, 32'(address_imem), 32'h001);
    @(negedge clock);
    check_eq({tag, "_valid_n2"}, 32'(insn_valid), 32'd1);
    check_eq({tag, "_pc_n2"}, 32'(insn_pc), 32'h000);
    check_eq({tag, "_addr_n2"}, 32'(address_imem), 32'h002);
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_valid"}, 32'(insn_valid), 32'd0);
    check_eq({tag, "_insn"}, insn, 32'd0);
    check_eq({tag, "_pc"}, 32'(insn_pc), 32'd0);
    check_eq({tag, "_illegal"}, 32'(insn_illegal), 32'd0);
    check_eq({tag, "_addr"}, 32'(address_imem), 32'h000);
  endtask

  initial begin
    logic [AW-1:0] prev_addr, a0, p0;
    logic [31:0]   w0;
    logic          found;

    load_exp(12'h000);
    mon_en = 1'b1;
    repeat (2) @(negedge clock);
    check_reset_vals("rst");

    // Reset release and streaming
    reset = 1'b0;
    check_restart("start");
    for (int i = 0; i < 6; i++) begin
      prev_addr = address_imem;
      @(negedge clock);
      check_eq("stream_valid", 32'(insn_valid), 32'd1);
      check_eq("stream_addr", 32'(address_imem), 32'(AW'(prev_addr + 1'b1)));
    end

    // Backpressure for 6 cycles
    @(posedge clock); #1 insn_ready = 1'b0;
    @(negedge clock);
    a0 = address_imem; p0 = insn_pc; w0 = insn;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check_eq("bp_addr_hold", 32'(address_imem), 32'(a0));
      check_eq("bp_pc_hold", 32'(insn_pc), 32'(p0));
      check_eq("bp_word_hold", insn, w0);
      check_eq("bp_valid", 32'(insn_valid), 32'd1);
    end
    check_eq("bp_count", 32'(dut.q_count), 32'd2);
    @(posedge clock); #1 insn_ready = 1'b1;
    @(negedge clock);
    check_eq("bp_resume_pc", 32'(insn_pc), 32'(p0));
    repeat (4) begin
      @(negedge clock);
      check_eq("bp_resume_valid", 32'(insn_valid), 32'd1);
    end

    // Redirect while 0x005 is in flight
    @(posedge clock); #1 reset = 1'b1;
    load_exp(12'h000);
    @(negedge clock) reset = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(posedge clock); #1;
      if (address_imem == 12'h006) found = 1'b1;
    end
    check_eq("rd_found_0x005", 32'(found), 32'd1);
    check_eq("rd_inflight", 32'(dut.inflight_q), 32'd1);
    redirect_valid = 1'b1; redirect_pc = 12'h100;
    load_exp(12'h100);
    @(negedge clock);
    @(posedge clock); #1 redirect_valid = 1'b0;
    @(negedge clock);
    check_eq("rd_valid_r1", 32'(insn_valid), 32'd0);
    check_eq("rd_addr_r1", 32'(address_imem), 32'h100);
    @(negedge clock);
    check_eq("rd_valid_r2", 32'(insn_valid), 32'd0);
    check_eq("rd_addr_r2", 32'(address_imem), 32'h101);
    @(negedge clock);
    check_eq("rd_valid_r3", 32'(insn_valid), 32'd1);
    check_eq("rd_pc_r3", 32'(insn_pc), 32'h100);

    // Back-to-back redirects (last wins) and PC wrap
    @(posedge clock); #1 redirect_valid = 1'b1; redirect_pc = 12'h050;
    load_exp(12'h050);
    @(posedge clock); #1 redirect_pc = 12'hFFE;
    load_exp(12'hFFE);
    @(posedge clock); #1 redirect_valid = 1'b0;
    @(negedge clock);
    check_eq("wrap_addr_r1", 32'(address_imem), 32'hFFE);
    @(negedge clock);
    check_eq("wrap_valid_r2", 32'(insn_valid), 32'd0);
    for (int i = 0; i < 4; i++) begin
      logic [AW-1:0] ep;
      ep = 12'hFFE + AW'(i);
      @(negedge clock);
      check_eq("wrap_valid", 32'(insn_valid), 32'd1);
      check_eq("wrap_pc", 32'(insn_pc), 32'(ep));
    end

    // Illegal opcode decode; fetch keeps flowing
    @(posedge clock); #1 redirect_valid = 1'b1; redirect_pc = 12'h200;
    load_exp(12'h200);
    @(posedge clock); #1 redirect_valid = 1'b0;
    repeat (2) @(negedge clock);
    for (int i = 0; i < 5; i++) begin
      logic exp_ill;
      exp_ill = (i == 1) || (i == 4);
      @(negedge clock);
      check_eq("ill_valid", 32'(insn_valid), 32'd1);
      check_eq("ill_pc", 32'(insn_pc), 32'(12'h200 + AW'(i)));
      check_eq("ill_flag", 32'(insn_illegal), 32'(exp_ill));
    end

    // Asynchronous reset with the queue full
    @(posedge clock); #1 insn_ready = 1'b0;
    repeat (3) @(negedge clock);
    check_eq("rstf_count_pre", 32'(dut.q_count), 32'd2);
    #2 reset = 1'b1;
    #1;
    check_reset_vals("rstf");
    check_eq("rstf_count", 32'(dut.q_count), 32'd0);
    load_exp(12'h000);
    insn_ready = 1'b1;
    @(negedge clock) reset = 1'b0;
    check_restart("rstf_restart");

    // Asynchronous reset with a word in flight
    repeat (3) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    check_eq("rsti_inflight", 32'(dut.inflight_q), 32'd0);
    check_reset_vals("rsti");
    load_exp(12'h000);
    @(negedge clock) reset = 1'b0;
    check_restart("rsti_restart");
    repeat (4) @(negedge clock);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
